delay_align_ctrl: RTL and testbench
===================================

Name: delay_align_ctrl

Overview:
- Skew-alignment controller for stream B against reference stream A.
- Measures cycle offset between B start-of-packet (b_sop) and A start-of-packet (a_sop).
- Programs the tap of an internal WIDTH x MAX_DLY register delay chain so delayed B data lands cycle-aligned with A.
- Sits at the PUSCH dimension-reduction input, between antenna data and per-symbol control.

Parameters:
- WIDTH, 16, data width of stream B.
- MAX_DLY, 32, max delay chain depth in cycles; legal taps 0..MAX_DLY.
- CNT_W, $clog2(MAX_DLY+2), width of skew counter and tap register.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- a_sop  in  1  reference stream start-of-packet pulse
- b_sop  in  1  stream B start-of-packet pulse
- b_vld  in  1  stream B valid
- b_data  in  WIDTH  stream B data
- relock  in  1  single-cycle request to re-measure
- o_vld  out  1  delayed b_vld
- o_sop  out  1  delayed b_sop
- o_data  out  WIDTH  delayed b_data
- tap  out  CNT_W  currently applied delay
- locked  out  1  alignment established
- err  out  1  skew exceeded MAX_DLY, or B lagged A

Behaviour:
- Delay chain: {b_vld, b_sop, b_data} shifted every cycle, no enable.
- Tap 0 is a combinational bypass; tap k is the k-th register stage.
- Outputs select the chain at the current tap.
- Reset, asynchronous:
  - chain cleared; state IDLE;
  - tap=0, locked=0, err=0;
  - o_vld=o_sop=0, o_data=0.
- FSM states: IDLE, MEASURE, LOCKED, ERROR.
- IDLE:
  - b_sop & !a_sop -> MEASURE; cnt=1.
  - b_sop & a_sop same cycle -> LOCKED; tap=0.
  - a_sop alone -> ERROR (B lags A).
- MEASURE:
  - cnt increments each cycle.
  - On a_sop: tap<=cnt, -> LOCKED, locked=1 from the next cycle.
  - cnt reaching MAX_DLY+1 without a_sop -> ERROR.
  - A second b_sop before a_sop restarts: cnt=1.
- LOCKED:
  - Each a_sop checks o_sop in the same cycle.
  - o_sop=1: stay LOCKED.
  - o_sop=0: locked<=0, -> IDLE (auto re-acquire). tap holds its value until the new measurement completes.
- ERROR:
  - err=1, locked=0, tap held.
  - Exit only on relock or reset, to IDLE with err cleared.
- relock in any state: -> IDLE next cycle, locked=0, err=0, tap held.
- relock has priority over simultaneous sop events.
- Tap changes take effect the cycle after the FSM update. Outputs may glitch for one packet across a tap change; no flush.
- Latency from a b input to o_*: exactly tap cycles (0 = same cycle).

Optional Feature:
- Macro: DELAY_ALIGN_STATS_EN.
- Defined:
  - adds output slip_cnt[15:0], saturating at 16'hFFFF;
  - increments on each LOCKED-state alignment miss and each ERROR entry;
  - cleared by reset only.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- b_sop at cycle 10, a_sop at cycle 15 -> tap=5, locked=1 at cycle 16. Next packet with b_sop@100, a_sop@105 -> o_sop=1 at 105, o_data equals b_data from 100.
- a_sop and b_sop both at cycle 20 from IDLE -> tap=0, locked=1 at cycle 21, o_data==b_data combinationally.
- b_sop, then no a_sop for MAX_DLY+1=33 cycles -> err=1, locked=0. relock pulse -> err=0, state IDLE next cycle.
- Locked at tap=5, then A skew changes to 8 -> miss detected at a_sop, locked drops. Next packet re-measures: tap=8, locked=1.
- Assert rst mid-MEASURE (cnt=3) -> all outputs 0 immediately, without a clock edge. After release, a fresh b_sop/a_sop pair locks correctly.
- With DELAY_ALIGN_STATS_EN: two misses plus one ERROR entry -> slip_cnt=3.

Source files
------------

// File: rtl/delay_align_ctrl.sv
// delay_align_ctrl: skew-alignment controller that delays stream B onto reference stream A
// Ports: clk, rst (async, active-high); a_sop reference start-of-packet;
//   b_sop/b_vld/b_data stream B; relock re-measure request;
//   o_vld/o_sop/o_data stream B delayed by tap cycles; tap applied delay;
//   locked alignment established; err skew beyond MAX_DLY or B lagging A.
// Optional: define DELAY_ALIGN_STATS_EN to add slip_cnt, a saturating count of
//   LOCKED-state alignment misses plus ERROR entries.
module delay_align_ctrl #(
    parameter int WIDTH   = 16,
    parameter int MAX_DLY = 32,
    parameter int CNT_W   = $clog2(MAX_DLY + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_sop,
    input  logic             b_sop,
    input  logic             b_vld,
    input  logic [WIDTH-1:0] b_data,
    input  logic             relock,
    output logic             o_vld,
    output logic             o_sop,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] tap,
    output logic             locked,
`ifdef DELAY_ALIGN_STATS_EN
    output logic             err,
    output logic [15:0]      slip_cnt
`else
    output logic             err
`endif
);
    localparam int DW = WIDTH + 2;
    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED, ERROR} state_t;
    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, tap_nxt;
    logic [DW-1:0] chain [1:MAX_DLY];
    logic [DW-1:0] cur, sel;
    assign cur = {b_vld, b_sop, b_data};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= MAX_DLY; k++) chain[k] <= '0;
        end else begin
            chain[1] <= cur;
            for (int k = 2; k <= MAX_DLY; k++) chain[k] <= chain[k-1];
        end
    end
    // tap 0 bypasses the chain so the output follows the input in the same cycle
    always_comb begin
        sel = cur;
        for (int k = 1; k <= MAX_DLY; k++) if (tap == CNT_W'(k)) sel = chain[k];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            tap   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            tap   <= tap_nxt;
        end
    end
    // cnt holds cycles elapsed since b_sop; timing out on cnt==MAX_DLY keeps every lockable tap legal
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tap_nxt   = tap;
        if (relock) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (b_sop && a_sop) begin
                        state_nxt = LOCKED;
                        tap_nxt   = '0;
                    end else if (b_sop) begin
                        state_nxt = MEASURE;
                        cnt_nxt   = CNT_W'(1);
                    end else if (a_sop) begin
                        state_nxt = ERROR;
                    end
                end
                MEASURE: begin
                    if (a_sop) begin
                        state_nxt = LOCKED;
                        tap_nxt   = cnt;
                    end else if (b_sop) begin
                        cnt_nxt = CNT_W'(1);
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(MAX_DLY)) state_nxt = ERROR;
                    end
                end
                LOCKED:  state_nxt = (a_sop && !sel[DW-2]) ? IDLE : LOCKED;
                default: state_nxt = ERROR;
            endcase
        end
    end
    // outputs are forced low while reset is asserted, even through the tap-0 bypass
    always_comb begin
        locked = state == LOCKED;
        err    = state == ERROR;
        o_vld  = !rst && sel[DW-1];
        o_sop  = !rst && sel[DW-2];
        o_data = rst ? '0 : sel[WIDTH-1:0];
    end
`ifdef DELAY_ALIGN_STATS_EN
    logic slip;
    assign slip = !relock && ((state == LOCKED && a_sop && !sel[DW-2]) ||
                              (state != ERROR && state_nxt == ERROR));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) slip_cnt <= '0;
        else if (slip && slip_cnt != 16'hFFFF) slip_cnt <= slip_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_delay_align_ctrl.sv
// tb_delay_align_ctrl: self-checking bench for delay_align_ctrl
module tb_delay_align_ctrl;
    localparam int W = 16, MD = 32, CW = $clog2(MD + 2);
    logic clk = 0, rst = 1, a_sop = 0, b_sop = 0, b_vld = 0, relock = 0;
    logic [W-1:0] b_data = '0;
    logic o_vld, o_sop, locked, err;
    logic [W-1:0] o_data;
    logic [CW-1:0] tap;
`ifdef DELAY_ALIGN_STATS_EN
    logic [15:0] slip_cnt;
`endif
    int checks = 0, errors = 0;
    always #5 clk = ~clk;

    delay_align_ctrl #(.WIDTH(W), .MAX_DLY(MD)) dut (
        .clk(clk), .rst(rst), .a_sop(a_sop), .b_sop(b_sop), .b_vld(b_vld),
        .b_data(b_data), .relock(relock), .o_vld(o_vld), .o_sop(o_sop),
        .o_data(o_data), .tap(tap), .locked(locked),
`ifdef DELAY_ALIGN_STATS_EN
        .err(err), .slip_cnt(slip_cnt));
`else
        .err(err));
`endif

    // reference model: history of past B beats plus timestamp of the pending b_sop
    typedef struct packed {logic v; logic s; logic [W-1:0] d;} beat_t;
    beat_t hq[$];
    int now, b_time, m_tap, m_slip;
    bit m_locked, m_err, m_meas;

    typedef struct packed {bit a, b, rl, v; logic [15:0] d; logic [5:0] t; bit lk, er, sp;} vec_t;
    vec_t tv [12];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, now);
        end
    endtask

    task automatic model_reset;
        hq.delete();
        now = 0; b_time = 0; m_tap = 0; m_slip = 0;
        m_locked = 0; m_err = 0; m_meas = 0;
    endtask

    task automatic cyc(input bit a, input bit b, input bit rl, input bit v, input logic [W-1:0] d);
        beat_t cb, eo;
        @(negedge clk);
        a_sop = a; b_sop = b; relock = rl; b_vld = v; b_data = d;
        #1;
        cb = {v, b, d};
        eo = (m_tap == 0) ? cb : (m_tap <= hq.size() ? hq[m_tap-1] : beat_t'(0));
        chk("o_vld", o_vld, eo.v);
        chk("o_sop", o_sop, eo.s);
        chk("o_data", o_data, eo.d);
        chk("tap", tap, m_tap);
        chk("locked", locked, m_locked);
        chk("err", err, m_err);
`ifdef DELAY_ALIGN_STATS_EN
        chk("slip_cnt", slip_cnt, m_slip);
`endif
        if (rl) begin
            m_meas = 0; m_locked = 0; m_err = 0;
        end else if (m_err) begin
        end else if (m_locked) begin
            if (a && !eo.s) begin m_locked = 0; m_slip++; end
        end else if (m_meas) begin
            if (a) begin m_tap = now - b_time; m_locked = 1; m_meas = 0; end
            else if (b) b_time = now;
            else if (now - b_time == MD) begin m_err = 1; m_meas = 0; m_slip++; end
        end else if (a && b) begin
            m_tap = 0; m_locked = 1;
        end else if (b) begin
            m_meas = 1; b_time = now;
        end else if (a) begin
            m_err = 1; m_slip++;
        end
        hq.push_front(cb);
        if (hq.size() > MD) void'(hq.pop_back());
        now++;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 1'($urandom), 16'($urandom));
    endtask

    initial begin
        tv = '{
            '{0,0,0,1,16'h1111,6'd0,0,0,0},
            '{1,1,0,1,16'hAAAA,6'd0,0,0,1},
            '{0,0,0,0,16'h1234,6'd0,1,0,0},
            '{1,0,0,1,16'h5555,6'd0,1,0,0},
            '{0,0,0,1,16'h6666,6'd0,0,0,0},
            '{1,0,0,1,16'h7777,6'd0,0,0,0},
            '{0,0,0,1,16'h8888,6'd0,0,1,0},
            '{0,1,0,1,16'h9999,6'd0,0,1,1},
            '{1,1,1,1,16'hABCD,6'd0,0,1,1},
            '{0,0,0,1,16'hBEEF,6'd0,0,0,0},
            '{1,1,0,1,16'hCAFE,6'd0,0,0,1},
            '{0,0,0,1,16'hF00D,6'd0,1,0,0}};
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_tap", tap, 0);
        chk("reset_locked", locked, 0);
        chk("reset_o_data", o_data, 0);
        rst = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(tv[i].a, tv[i].b, tv[i].rl, tv[i].v, tv[i].d);
            chk("vec_tap", tap, tv[i].t);
            chk("vec_locked", locked, tv[i].lk);
            chk("vec_err", err, tv[i].er);
            chk("vec_o_sop", o_sop, tv[i].sp);
            chk("vec_o_data", o_data, tv[i].d);
        end
        // skew of 5 locks tap 5; next packet lands aligned
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 16'h0B10);
        idle(4);
        cyc(1, 0, 0, 1, 16'h3333);
        idle(1);
        chk("t5_tap", tap, 5);
        chk("t5_locked", locked, 1);
        idle(10);
        cyc(0, 1, 0, 1, 16'hD100);
        idle(4);
        cyc(1, 0, 0, 1, 16'h2222);
        chk("t5_o_sop", o_sop, 1);
        chk("t5_o_data", o_data, 16'hD100);
        idle(1);
        chk("t5_still_locked", locked, 1);
        // simultaneous sops lock at tap 0 with combinational bypass
        cyc(0, 0, 1, 0, 0);
        cyc(1, 1, 0, 1, 16'h2020);
        cyc(0, 0, 0, 1, 16'h2121);
        chk("t0_tap", tap, 0);
        chk("t0_locked", locked, 1);
        chk("t0_o_data", o_data, 16'h2121);
        // timeout after MAX_DLY+1 cycles without a_sop, then relock
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 16'h0001);
        idle(32);
        chk("to_err_early", err, 0);
        idle(1);
        chk("to_err", err, 1);
        chk("to_locked", locked, 0);
        cyc(0, 0, 1, 0, 0);
        chk("to_err_hold", err, 1);
        idle(1);
        chk("to_err_clr", err, 0);
        // skew change 5 -> 8 triggers a miss and re-measure
        cyc(0, 1, 0, 1, 16'h0005);
        idle(4);
        cyc(1, 0, 0, 1, 0);
        idle(6);
        cyc(0, 1, 0, 1, 16'h0008);
        idle(7);
        cyc(1, 0, 0, 1, 0);
        chk("sk_locked_pre", locked, 1);
        chk("sk_o_sop", o_sop, 0);
        idle(1);
        chk("sk_locked_drop", locked, 0);
        chk("sk_tap_hold", tap, 5);
        cyc(0, 1, 0, 1, 16'h0808);
        idle(7);
        cyc(1, 0, 0, 1, 0);
        idle(1);
        chk("sk_tap", tap, 8);
        chk("sk_locked", locked, 1);
        // second b_sop restarts the measurement
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0);
        idle(3);
        cyc(0, 1, 0, 1, 0);
        idle(1);
        cyc(1, 0, 0, 1, 0);
        idle(1);
        chk("rs_tap", tap, 2);
        // asynchronous reset mid-measure
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 16'h4444);
        idle(3);
        b_vld = 1; b_sop = 1; b_data = 16'hFFFF;
        rst = 1;
        #1;
        chk("ar_tap", tap, 0);
        chk("ar_locked", locked, 0);
        chk("ar_err", err, 0);
        chk("ar_o_vld", o_vld, 0);
        chk("ar_o_sop", o_sop, 0);
        chk("ar_o_data", o_data, 0);
        model_reset();
        a_sop = 0; b_sop = 0; b_vld = 0; b_data = '0; relock = 0;
        @(negedge clk);
        rst = 0;
        cyc(0, 1, 0, 1, 16'h5151);
        idle(2);
        cyc(1, 0, 0, 1, 0);
        idle(1);
        chk("ar_relock_tap", tap, 3);
        chk("ar_relock_locked", locked, 1);
`ifdef DELAY_ALIGN_STATS_EN
        cyc(0, 0, 1, 0, 0);
        cyc(1, 1, 0, 1, 0);
        idle(1);
        cyc(1, 0, 0, 1, 0);
        idle(1);
        cyc(1, 1, 0, 1, 0);
        idle(1);
        cyc(1, 0, 0, 1, 0);
        idle(1);
        cyc(1, 0, 0, 1, 0);
        idle(1);
        chk("st_slip_cnt", slip_cnt, 3);
`endif
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
                1'($urandom), 16'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
